// File: rtl/mem_loader.sv
// Byte-stream memory loader: packs little-endian bytes into 32-bit words, writes them to
// memory, then reads every word back and flags a mismatch between readback and write sums.
module mem_loader #(
   parameter int WIDTH = 32,
   parameter int WORD  = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      len,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_we,
   output logic [31:0]      rd_addr,
   input  logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      checksum
);

   localparam logic [31:0] WORD_L = 32'(WORD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_VERIFY,
      S_DONE
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] len_q, len_d;
   logic [31:0] widx_q, widx_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] word_q, word_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [31:0] vcnt_q, vcnt_d;
   logic [31:0] csum_q, csum_d;
   logic [31:0] rsum_q, rsum_d;
   logic        err_q, err_d;
   logic [31:0] rsum_next;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         widx_q    <= '0;
         bcnt_q    <= '0;
         word_q    <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_addr_q <= '0;
         vcnt_q    <= '0;
         csum_q    <= '0;
         rsum_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         widx_q    <= widx_d;
         bcnt_q    <= bcnt_d;
         word_q    <= word_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rd_addr_q <= rd_addr_d;
         vcnt_q    <= vcnt_d;
         csum_q    <= csum_d;
         rsum_q    <= rsum_d;
         err_q     <= err_d;
      end
   end

   // NOTE: every variable gets a hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      widx_d    = widx_q;
      bcnt_d    = bcnt_q;
      word_d    = word_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_addr_d = rd_addr_q;
      vcnt_d    = vcnt_q;
      csum_d    = csum_q;
      rsum_d    = rsum_q;
      err_d     = err_q;
      rsum_next = rsum_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = (len > WORD_L) ? WORD_L : len;
               widx_d  = '0;
               bcnt_d  = '0;
               csum_d  = '0;
               rsum_d  = '0;
               err_d   = 1'b0;
               state_d = (len == '0) ? S_DONE : S_RECV;
            end
         end

         S_RECV: begin
            if (in_valid) begin
               // Shifting in from the top leaves byte 0 in bits [7:0] after four bytes.
               word_d = {in_data, word_q[31:8]};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  addr_d  = widx_q;
                  wdata_d = word_d;
                  state_d = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            csum_d = csum_q + wdata_q;
            if (widx_q == len_q - 32'd1) begin
               rd_addr_d = '0;
               vcnt_d    = '0;
               state_d   = S_VERIFY;
            end else begin
               widx_d  = widx_q + 32'd1;
               state_d = S_RECV;
            end
         end

         S_VERIFY: begin
            // Cycle 0 only issues the first address; data for address k arrives in cycle k+1.
            if (vcnt_q != '0) begin
               rsum_next = rsum_q + rd_data;
            end
            rsum_d = rsum_next;
            if (vcnt_q == len_q) begin
               err_d   = (rsum_next != csum_q);
               state_d = S_DONE;
            end else begin
               vcnt_d = vcnt_q + 32'd1;
               if (vcnt_q + 32'd1 < len_q) begin
                  rd_addr_d = vcnt_q + 32'd1;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == S_RECV);
   assign mem_we    = (state_q == S_WRITE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rd_addr   = rd_addr_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign checksum  = csum_q;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: a byte-level reference model predicts the written words,
// checksum, readback addresses and error flag; a small synchronous memory answers readback.
module tb_mem_loader;

   localparam int WORDS = 16;
   localparam int AW    = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] len = '0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] rd_addr;
   logic [31:0] rd_data = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] checksum;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [31:0] mem [WORDS];
   bit          corrupt_rd = 1'b0;

   logic [7:0]  stim [$];
   logic [31:0] wa_q [$];
   logic [31:0] wd_q [$];
   logic [31:0] ra_q [$];
   int          done_cnt = 0;
   int          busy_cnt = 0;

   mem_loader #(
      .WIDTH(32),
      .WORD (WORDS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_we   (mem_we),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .checksum (checksum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Dual-port memory: write port 0, synchronous read port 1 with optional corruption.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[AW-1:0]] <= mem_wdata;
      rd_data <= mem[rd_addr[AW-1:0]] ^ {31'b0, corrupt_rd};
   end

   // Observe the bus away from the active edge.
   always @(negedge clk) begin
      if (mem_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_wdata);
      end
      if (busy && !in_ready && !mem_we && !done) ra_q.push_back(rd_addr);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic run_session(input logic [31:0] l, input int gap, input bit noise, input bit corrupt);
      int unsigned n;
      logic [31:0] exp_w [$];
      logic [31:0] exp_sum;
      logic [31:0] w;
      int          gaps_total;
      int          t0;
      int          wait_cnt;
      bit          acc;

      n = (l > WORDS) ? WORDS : l;
      while (stim.size() < 4 * n) stim.push_back(8'($urandom));
      exp_sum = '0;
      for (int i = 0; i < int'(n); i++) begin
         w = 32'(stim[4*i]) + (32'(stim[4*i+1]) << 8) + (32'(stim[4*i+2]) << 16)
           + (32'(stim[4*i+3]) << 24);
         exp_w.push_back(w);
         exp_sum = exp_sum + w;
      end

      corrupt_rd = corrupt;
      wa_q.delete();
      wd_q.delete();
      ra_q.delete();
      done_cnt   = 0;
      busy_cnt   = 0;
      gaps_total = 0;

      @(negedge clk);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
      t0    = cyc;
      if (n == 0) check("len0_done_next_cycle", 32'(done), 32'd1);
      else        check("busy_after_start", 32'(busy), 32'd1);

      for (int k = 0; k < int'(4 * n); k++) begin
         int g;
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         gaps_total += g;
         repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            if (noise) begin
               start = 1'($urandom);
               len   = $urandom;
            end
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = stim[k];
         if (noise) begin
            start = 1'($urandom);
            len   = $urandom;
         end
         wait_cnt = 0;
         do begin
            acc = in_ready;
            @(negedge clk);
            wait_cnt++;
         end while (!acc && wait_cnt < 50);
         if (!acc) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            start    = 1'b0;
            stim.delete();
            return;
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;

      wait_cnt = 0;
      while (!done && wait_cnt < 8 * WORDS + 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("done_seen", 32'(done), 32'd1);
      if (n > 0 && gaps_total == 0) check("done_latency", 32'(cyc - t0), 32'(6 * n + 1));
      check("checksum", checksum, exp_sum);
      check("err", 32'(err), 32'(corrupt));

      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      check("done_pulse_count", 32'(done_cnt), 32'd1);
      check("checksum_held", checksum, exp_sum);
      check("write_count", 32'(wa_q.size()), 32'(n));
      for (int i = 0; i < int'(n) && i < wa_q.size(); i++) begin
         check("write_addr", wa_q[i], 32'(i));
         check("write_data", wd_q[i], exp_w[i]);
      end
      if (n == 0) begin
         check("len0_busy_cycles", 32'(busy_cnt), 32'd1);
      end else begin
         check("verify_cycles", 32'(ra_q.size()), 32'(n + 1));
         for (int i = 0; i < int'(n) && i < ra_q.size(); i++) check("verify_addr", ra_q[i], 32'(i));
      end
      stim.delete();
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = '0;

      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_rd_addr", rd_addr, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      rst = 1'b1;

      // Bytes 01..08, first without stalls, then with three idle cycles before each byte.
      for (int i = 1; i <= 8; i++) stim.push_back(8'(i));
      run_session(32'd2, 0, 1'b0, 1'b0);
      check("fixed_checksum", checksum, 32'h0C0A0806);
      for (int i = 1; i <= 8; i++) stim.push_back(8'(i));
      run_session(32'd2, 3, 1'b0, 1'b0);
      check("fixed_checksum_stalled", checksum, 32'h0C0A0806);

      run_session(32'd0, 0, 1'b0, 1'b0);
      run_session(32'd1, 0, 1'b0, 1'b1);
      run_session(32'd20, 0, 1'b0, 1'b0);

      // Reset in the middle of a word.
      @(negedge clk);
      start = 1'b1;
      len   = 32'd3;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(negedge clk);
      in_data  = 8'hBB;
      @(negedge clk);
      in_valid = 1'b0;
      wa_q.delete();
      #2 rst = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_checksum", checksum, 32'd0);
      repeat (3) @(negedge clk);
      check("midrst_no_write", 32'(wa_q.size()), 32'd0);
      rst = 1'b1;
      run_session(32'd1, 0, 1'b0, 1'b0);

      for (int s = 0; s < 10; s++) begin
         run_session(32'($urandom_range(0, 20)), ($urandom_range(0, 1) == 0) ? -1 : 0,
                     1'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
